ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Multi-cycle multiply/divide unit attached to the EX stage, owning the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from EX and stalls the pipeline through busy_o until the result is written to HI/LO.
- Generalises the single-cycle logic path to a parametrised width, with configurable multiply latency, an iterative divider, and a flush/abort path.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits; must be at least 8.
MUL_LAT, 3, cycles from the start cycle to done for multiplies; must be at least 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
start_i  in  1  request a new operation; sampled only in IDLE.
op_i  in  2  operation select: 00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
opa_i  in  DATA_W  multiplicand / dividend.
opb_i  in  DATA_W  multiplier / divisor.
flush_i  in  1  abort the in-flight operation (exception or branch flush).
hi_we_i  in  1  MTHI write enable.
hi_wdata_i  in  DATA_W  MTHI data.
lo_we_i  in  1  MTLO write enable.
lo_wdata_i  in  DATA_W  MTLO data.
busy_o  out  1  operation in flight; EX stalls while this is high.
done_o  out  1  one-cycle pulse; HI/LO already hold the new result while it is high.
hi_o  out  DATA_W  HI register.
lo_o  out  DATA_W  LO register.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, hi_o=0, lo_o=0, done_o=0, all counters=0. Asserting reset mid-operation discards the operation.
- States:
  - IDLE.
  - MUL: counts MUL_LAT-1 cycles.
  - DIV: DATA_W iterations.
  - DZ: divide-by-zero, one cycle.
- busy_o = (state != IDLE), decoded from registered state.
- Start capture: start_i && !flush_i in IDLE latches op, opa and opb on that edge. start_i outside IDLE is ignored.
- Multiply:
  - Signed for MULT, unsigned for MULTU; full 2*DATA_W product goes to {HI,LO}.
  - With start in cycle 0, done_o is high in cycle MUL_LAT and HI/LO are updated on the same edge.
  - MUL_LAT=1 means no wait cycles.
- Divide:
  - Restoring radix-2 on magnitudes, one quotient bit per cycle.
  - With start in cycle 0, done_o is high in cycle DATA_W+1.
  - LO = quotient, HI = remainder.
  - Signed (DIV): quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - MIN / -1 gives LO=MIN, HI=0; no trap.
- Divide by zero (opb=0 at start, DIV or DIVU): go to DZ. done_o in cycle 2, LO = all ones, HI = opa_i, no iteration.
- done_o is a single-cycle pulse; the unit returns to IDLE on the same edge that raises done_o. A new start may be accepted in the done_o cycle.
- Flush:
  - flush_i in any non-IDLE state: return to IDLE on the next edge; HI/LO untouched; no done_o.
  - flush_i on the completion edge suppresses both the write and done_o.
  - flush_i in IDLE with start_i: start is ignored.
- MTHI/MTLO:
  - hi_we_i/lo_we_i write on the edge in any state.
  - If a completion write occurs on the same edge, the completion wins.
  - Writes made during busy are overwritten by the completion.
- Arithmetic:
  - Internal magnitudes are DATA_W bits unsigned; the partial remainder is DATA_W+1 bits.
  - No result ever depends on bits beyond DATA_W of the operands.

Test Plan:
- MULT, opa=0xFFFFFFFD (-3), opb=7, DATA_W=32, MUL_LAT=3 -> done_o in cycle 3; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy_o high in cycles 1-2 and low in cycle 3.
- MULTU, opa=0xFFFFFFFF, opb=2 -> HI=0x00000001, LO=0xFFFFFFFE; back-to-back start in the done cycle is accepted.
- DIV, opa=0xFFFFFFF9 (-7), opb=2 -> done_o in cycle 33; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU, opa=100, opb=0 -> done_o in cycle 2; LO=0xFFFFFFFF, HI=0x00000064.
- DIVU 1000/7 with flush_i pulsed in cycle 10 -> busy_o low from cycle 11; HI/LO keep the prior values; done_o never asserted. Repeat with rst_i asserted mid-divide -> HI=LO=0 immediately.
- DATA_W=16: DIVU 0xFFFF/0x0003 -> LO=0x5555, HI=0 at cycle 17. hi_we_i=1 (data 0x1234) on the completion edge -> HI=0 (completion wins).

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Multi-cycle multiply/divide unit for the EX stage. Owns the architectural
//   HI/LO registers. MULT/MULTU finish after MUL_LAT cycles. DIV/DIVU use a
//   restoring radix-2 divider on magnitudes, one quotient bit per cycle.
//   A zero divisor takes a one-cycle shortcut: LO = all ones, HI = dividend.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   start_i, op_i           request and op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opa_i, opb_i            multiplicand/dividend, multiplier/divisor
//   flush_i                 abort the in-flight operation; no write, no done
//   hi_we_i/hi_wdata_i      MTHI write port
//   lo_we_i/lo_wdata_i      MTLO write port
//   busy_o                  operation in flight (EX stalls)
//   done_o                  one-cycle pulse; HI/LO already hold the result
//   hi_o, lo_o              HI/LO registers
module ex_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic [DATA_W-1:0] hi_wdata_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] lo_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int MAX_CNT = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DZ
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                mul_signed_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;       // raw multiplier, or divisor magnitude
  logic [DATA_W-1:0]   rem_q;       // partial remainder (always < divisor)
  logic [DATA_W-1:0]   quo_q;       // dividend bits shift out, quotient bits shift in
  logic                quo_neg_q;
  logic                rem_neg_q;

  logic                in_idle;
  logic                is_sdiv;
  logic                a_sign;
  logic                b_sign;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic                mul_signed;
  logic [DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]   mul_b;
  logic [2*DATA_W-1:0] mul_ext_a;
  logic [2*DATA_W-1:0] mul_ext_b;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_trial;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   quo_nx;
  logic [DATA_W-1:0]   div_lo;
  logic [DATA_W-1:0]   div_hi;

  assign busy_o = (state != S_IDLE);

  always_comb begin
    in_idle = (state == S_IDLE);

    // Operand magnitudes for the divider, taken at start.
    is_sdiv = (op_i == 2'b10);
    a_sign  = is_sdiv & opa_i[DATA_W-1];
    b_sign  = is_sdiv & opb_i[DATA_W-1];
    a_mag   = a_sign ? -opa_i : opa_i;
    b_mag   = b_sign ? -opb_i : opb_i;

    // With MUL_LAT=1 the product is written on the start edge straight from
    // the inputs; otherwise it comes from the captured operands.
    mul_signed = in_idle ? ~op_i[0] : mul_signed_q;
    mul_a      = in_idle ? opa_i : opa_q;
    mul_b      = in_idle ? opb_i : opb_q;
    mul_ext_a  = mul_signed ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a} : {{DATA_W{1'b0}}, mul_a};
    mul_ext_b  = mul_signed ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b} : {{DATA_W{1'b0}}, mul_b};
    product    = mul_ext_a * mul_ext_b;

    // One restoring step; the borrow bit of the DATA_W+1 bit trial decides.
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_trial = rem_shift - {1'b0, opb_q};
    rem_nx    = rem_trial[DATA_W] ? rem_shift[DATA_W-1:0] : rem_trial[DATA_W-1:0];
    quo_nx    = {quo_q[DATA_W-2:0], ~rem_trial[DATA_W]};

    // The final step's result is sign-corrected and written on the same edge.
    div_lo = quo_neg_q ? -quo_nx : quo_nx;
    div_hi = rem_neg_q ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mul_signed_q <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      done_o       <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      done_o <= 1'b0;

      // MTHI/MTLO; a completion write below on the same edge takes priority.
      if (hi_we_i) hi_o <= hi_wdata_i;
      if (lo_we_i) lo_o <= lo_wdata_i;

      case (state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            mul_signed_q <= ~op_i[0];
            opa_q        <= opa_i;
            opb_q        <= op_i[1] ? b_mag : opb_i;
            rem_q        <= '0;
            quo_q        <= a_mag;
            quo_neg_q    <= a_sign ^ b_sign;
            rem_neg_q    <= a_sign;
            if (!op_i[1]) begin
              if (MUL_LAT == 1) begin
                hi_o   <= product[2*DATA_W-1:DATA_W];
                lo_o   <= product[DATA_W-1:0];
                done_o <= 1'b1;
              end else begin
                state <= S_MUL;
                cnt   <= MUL_CNT_INIT;
              end
            end else if (opb_i == '0) begin
              state <= S_DZ;
            end else begin
              state <= S_DIV;
              cnt   <= DIV_CNT_INIT;
            end
          end
        end

        S_MUL: begin
          if (flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            hi_o   <= product[2*DATA_W-1:DATA_W];
            lo_o   <= product[DATA_W-1:0];
            done_o <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DIV: begin
          if (flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (cnt == '0) begin
              hi_o   <= div_hi;
              lo_o   <= div_lo;
              done_o <= 1'b1;
              state  <= S_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        S_DZ: begin
          if (!flush_i) begin
            hi_o   <= opa_q;
            lo_o   <= '1;
            done_o <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  localparam int W0 = 32;
  localparam int L0 = 3;
  localparam int W1 = 16;
  localparam int L1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start32, flush32, hiwe32, lowe32, busy32, done32;
  logic [1:0]    op32;
  logic [W0-1:0] opa32, opb32, hid32, lod32, hi32, lo32;
  logic          start16, flush16, hiwe16, lowe16, busy16, done16;
  logic [1:0]    op16;
  logic [W1-1:0] opa16, opb16, hid16, lod16, hi16, lo16;

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned m_hi[2];
  longint unsigned m_lo[2];

  ex_muldiv_unit #(.DATA_W(W0), .MUL_LAT(L0)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .op_i(op32),
    .opa_i(opa32), .opb_i(opb32), .flush_i(flush32),
    .hi_we_i(hiwe32), .hi_wdata_i(hid32), .lo_we_i(lowe32), .lo_wdata_i(lod32),
    .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
  );

  ex_muldiv_unit #(.DATA_W(W1), .MUL_LAT(L1)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .op_i(op16),
    .opa_i(opa16), .opb_i(opb16), .flush_i(flush16),
    .hi_we_i(hiwe16), .hi_wdata_i(hid16), .lo_we_i(lowe16), .lo_wdata_i(lod16),
    .busy_o(busy16), .done_o(done16), .hi_o(hi16), .lo_o(lo16)
  );

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel != 0) ? W1 : W0;
  endfunction

  function automatic longint unsigned mask_of(input int sel);
    return (64'd1 << width_of(sel)) - 64'd1;
  endfunction

  function automatic longint unsigned get_hi(input int sel);
    return (sel != 0) ? 64'(hi16) : 64'(hi32);
  endfunction

  function automatic longint unsigned get_lo(input int sel);
    return (sel != 0) ? 64'(lo16) : 64'(lo32);
  endfunction

  function automatic longint unsigned get_busy(input int sel);
    return (sel != 0) ? 64'(busy16) : 64'(busy32);
  endfunction

  function automatic longint unsigned get_done(input int sel);
    return (sel != 0) ? 64'(done16) : 64'(done32);
  endfunction

  // Cycles from start to the done pulse, straight from the timing rules.
  function automatic int lat_of(input int sel, input int op, input longint unsigned b);
    if (op < 2) return (sel != 0) ? L1 : L0;
    if (b == 0) return 2;
    return width_of(sel) + 1;
  endfunction

  task automatic drive(input int sel, input logic st, input int op,
                       input longint unsigned a, input longint unsigned b, input logic fl);
    if (sel == 0) begin
      start32 = st; op32 = 2'(op); opa32 = a[31:0]; opb32 = b[31:0]; flush32 = fl;
    end else begin
      start16 = st; op16 = 2'(op); opa16 = a[15:0]; opb16 = b[15:0]; flush16 = fl;
    end
  endtask

  task automatic drive_mt(input int sel, input logic hwe, input longint unsigned hd,
                          input logic lwe, input longint unsigned ld);
    if (sel == 0) begin
      hiwe32 = hwe; hid32 = hd[31:0]; lowe32 = lwe; lod32 = ld[31:0];
    end else begin
      hiwe16 = hwe; hid16 = hd[15:0]; lowe16 = lwe; lod16 = ld[15:0];
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic ref_op(input int sel, input int op, input longint unsigned a,
                        input longint unsigned b, output longint unsigned hi,
                        output longint unsigned lo);
    int w;
    longint unsigned m, pu;
    longint sa, sb, q, r;
    w  = width_of(sel);
    m  = mask_of(sel);
    sa = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a | ~m) : longint'(a);
    sb = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b | ~m) : longint'(b);
    case (op)
      0: begin pu = sa * sb; lo = pu & m; hi = (pu >> w) & m; end
      1: begin pu = a * b;   lo = pu & m; hi = (pu >> w) & m; end
      default: begin
        if (b == 0) begin
          lo = m; hi = a;
        end else if (op == 3) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          pu = q; lo = pu & m;
          pu = r; hi = pu & m;
        end
      end
    endcase
  endtask

  // Called on a negedge (cycle 0); returns on the negedge of the done cycle,
  // or after the flush/reset has been observed.
  task automatic do_op(input int sel, input int op, input longint unsigned a,
                       input longint unsigned b, input int fl_at, input int rs_at,
                       input int mt_at);
    int lat;
    bit saw_done;
    longint unsigned eh, el;
    string nm;
    lat = lat_of(sel, op, b);
    ref_op(sel, op, a, b, eh, el);
    nm = $sformatf("w%0d op%0d a=%0h b=%0h", width_of(sel), op, a, b);
    drive(sel, 1'b1, op, a, b, 1'b0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, op, a, b, 1'b0);
      if (k == mt_at + 1) drive_mt(sel, 1'b0, 0, 1'b0, 0);
      if (fl_at >= 0 && k == fl_at + 1) begin
        drive(sel, 1'b0, op, a, b, 1'b0);
        check_eq({nm, " busy after flush"}, get_busy(sel), 0);
        saw_done = (get_done(sel) != 0);
        repeat (lat - k + 2) begin
          @(negedge clk);
          if (get_done(sel) != 0) saw_done = 1'b1;
        end
        check_eq({nm, " done after flush"}, 64'(saw_done), 0);
        check_eq({nm, " hi kept on flush"}, get_hi(sel), m_hi[sel]);
        check_eq({nm, " lo kept on flush"}, get_lo(sel), m_lo[sel]);
        return;
      end
      if (rs_at >= 0 && k == rs_at) begin
        rst = 1'b1;
        #1;
        check_eq({nm, " busy in reset"}, get_busy(sel), 0);
        check_eq({nm, " hi in reset"}, get_hi(sel), 0);
        check_eq({nm, " lo in reset"}, get_lo(sel), 0);
        m_hi = '{0, 0};
        m_lo = '{0, 0};
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      check_eq($sformatf("%s done c%0d", nm, k), get_done(sel), (k == lat) ? 1 : 0);
      check_eq($sformatf("%s busy c%0d", nm, k), get_busy(sel), (k < lat) ? 1 : 0);
      if (k == lat) begin
        check_eq({nm, " hi"}, get_hi(sel), eh);
        check_eq({nm, " lo"}, get_lo(sel), el);
        m_hi[sel] = eh;
        m_lo[sel] = el;
      end
      if (k == fl_at) drive(sel, 1'b0, op, a, b, 1'b1);
      if (k == mt_at) drive_mt(sel, 1'b1, 64'h1234 & mask_of(sel), 1'b1, 64'h4321 & mask_of(sel));
    end
  endtask

  task automatic mt_idle(input int sel, input logic hwe, input longint unsigned h,
                         input logic lwe, input longint unsigned l);
    drive_mt(sel, hwe, h, lwe, l);
    @(negedge clk);
    drive_mt(sel, 1'b0, 0, 1'b0, 0);
    if (hwe) m_hi[sel] = h;
    if (lwe) m_lo[sel] = l;
    check_eq($sformatf("w%0d mthi", width_of(sel)), get_hi(sel), m_hi[sel]);
    check_eq($sformatf("w%0d mtlo", width_of(sel)), get_lo(sel), m_lo[sel]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int sel, op, fl, mt, lat, r;
    longint unsigned m, a, b;

    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 0, 1'b0);
    drive_mt(0, 1'b0, 0, 1'b0, 0);
    drive_mt(1, 1'b0, 0, 1'b0, 0);
    m_hi = '{0, 0};
    m_lo = '{0, 0};
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_eq($sformatf("reset busy s%0d", s), get_busy(s), 0);
      check_eq($sformatf("reset done s%0d", s), get_done(s), 0);
      check_eq($sformatf("reset hi s%0d", s), get_hi(s), 0);
      check_eq($sformatf("reset lo s%0d", s), get_lo(s), 0);
    end
    rst = 1'b0;

    // Directed cases
    do_op(0, 0, 64'hFFFF_FFFD, 64'd7, -1, -1, -1);
    @(negedge clk);
    do_op(0, 1, 64'hFFFF_FFFF, 64'd2, -1, -1, -1);
    do_op(0, 2, 64'hFFFF_FFF9, 64'd2, -1, -1, -1);       // started in the done cycle
    @(negedge clk);
    do_op(0, 2, 64'h8000_0000, 64'hFFFF_FFFF, -1, -1, -1);
    @(negedge clk);
    do_op(0, 3, 64'd100, 64'd0, -1, -1, -1);
    @(negedge clk);
    do_op(0, 3, 64'd1000, 64'd7, 10, -1, -1);
    mt_idle(0, 1'b1, 64'hAAAA_5555, 1'b1, 64'h0000_1111);
    do_op(0, 3, 64'd1000, 64'd7, -1, 12, -1);
    do_op(1, 3, 64'hFFFF, 64'h0003, -1, -1, 16);           // MTHI on completion edge
    do_op(1, 0, 64'hFFFD, 64'h0007, -1, -1, -1);
    do_op(1, 2, 64'h8000, 64'hFFFF, -1, -1, -1);
    @(negedge clk);

    // start together with flush in IDLE is ignored
    drive(0, 1'b1, 3, 64'd5, 64'd1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 3, 64'd5, 64'd1, 1'b0);
    check_eq("idle flush busy", get_busy(0), 0);
    @(negedge clk);
    check_eq("idle flush done", get_done(0), 0);
    check_eq("idle flush lo", get_lo(0), m_lo[0]);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 1);
      op  = $urandom_range(0, 3);
      m   = mask_of(sel);
      a   = 64'($urandom) & m;
      r   = $urandom_range(0, 9);
      if (r == 0) b = 0;
      else if (r == 1) begin a = (m >> 1) + 1; b = m; end
      else if (r == 2) b = $urandom_range(1, 15);
      else b = 64'($urandom) & m;
      lat = lat_of(sel, op, b);
      fl = -1;
      mt = -1;
      r = $urandom_range(0, 7);
      if (lat > 1) begin
        if (r == 0) fl = $urandom_range(1, lat - 1);
        else if (r == 1) mt = $urandom_range(1, lat - 1);
      end
      if ($urandom_range(0, 3) == 0)
        mt_idle(sel, 1'($urandom_range(0, 1)), 64'($urandom) & m,
                1'($urandom_range(0, 1)), 64'($urandom) & m);
      do_op(sel, op, a, b, fl, -1, mt);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
